// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths and store buffer entry type for the MEM stage
package mem_pkg;

    localparam int DEFAULT_DEPTH  = 4;
    localparam int DEFAULT_ADDR_W = 9;
    localparam int DEFAULT_DATA_W = 16;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] addr;
        logic [DEFAULT_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_entry_array.sv
// rtl/sb_entry_array.sv - circular store queue with youngest-match address search
module sb_entry_array
    import mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  sb_entry_t                 push_entry,
    input  logic                      pop,
    output sb_entry_t                 head_entry,
    output logic [$clog2(DEPTH):0]    count,
    input  logic [DEFAULT_ADDR_W-1:0] lookup_addr,
    output logic                      hit,
    output logic [DEFAULT_DATA_W-1:0] hit_data
);

    localparam int PW = $clog2(DEPTH);

    sb_entry_t         entries [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;

    // Entry payload needs no reset: only slots inside the head..tail window are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count disambiguates full/empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head_entry = entries[head];

    // Walk valid slots oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        logic [PW-1:0] slot;
        hit      = 1'b0;
        hit_data = '0;
        slot     = head;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head + PW'(i);
            if (i < int'(count) && entries[slot].addr == lookup_addr) begin
                hit      = 1'b1;
                hit_data = entries[slot].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - MEM-stage store buffer with drain priority and load forwarding
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     req_ready,
    input  logic                     flush,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [DATA_W-1:0]        mem_data_in,
    input  logic [DATA_W-1:0]        mem_data_out,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    sb_entry_t   head_entry;
    sb_entry_t   push_entry;
    logic        full;
    logic        drain;
    logic        accept;
    logic        push;
    logic        load_acc;
    logic        hit;
    logic [DATA_W-1:0] hit_data;

    assign full  = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty = (count == '0);

    // Ready comes from registered occupancy only, so a full buffer never accepts in the drain cycle.
    assign req_ready = !full && !flush;
    assign accept    = req_valid && req_ready;
    assign push      = accept && req_we;
    assign load_acc  = accept && !req_we;

    // Full forces a drain; otherwise flush or an idle pipeline cycle lets the head retire.
    // None of these can coincide with an accepted request, so push and pop are exclusive.
    assign drain = !reset && (full || (!empty && (flush || !req_valid)));

    assign push_entry = '{addr: req_addr, data: req_wdata};

    sb_entry_array #(
        .DEPTH (DEPTH)
    ) u_entries (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (drain),
        .head_entry  (head_entry),
        .count       (count),
        .lookup_addr (req_addr),
        .hit         (hit),
        .hit_data    (hit_data)
    );

    // Memory port: drains own the port; an accepted load borrows it for its read address.
    always_comb begin
        mem_we      = 1'b0;
        mem_address = '0;
        mem_data_in = '0;
        if (drain) begin
            mem_we      = 1'b1;
            mem_address = head_entry.addr;
            mem_data_in = head_entry.data;
        end else if (load_acc) begin
            mem_address = req_addr;
        end
    end

    // Load result is registered; buffered data shadows memory so pending stores look committed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= load_acc;
            if (load_acc) begin
                rsp_data <= hit ? hit_data : mem_data_out;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed and randomized checks of store_buffer against a queue model
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [8:0]  req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        flush;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        mem_we;
    logic [8:0]  mem_address;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        empty;
    logic [2:0]  count;

    logic [15:0] mem [0:511] = '{default: 16'h0000};

    typedef struct {
        logic [8:0]  addr;
        logic [15:0] data;
    } ent_t;

    ent_t        q[$];
    logic [15:0] refmem [0:511];
    logic [15:0] last_rsp;
    int          checks = 0;
    int          errors = 0;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(9), .DATA_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .flush        (flush),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .mem_we       (mem_we),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .empty        (empty),
        .count        (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_address] <= mem_data_in;
    end

    assign mem_data_out = mem[mem_address];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic we, input logic [8:0] a,
                         input logic [15:0] d, input logic fl);
        int          qs;
        logic        e_ready;
        logic        e_drain;
        logic        e_load;
        logic [8:0]  e_addr;
        logic [15:0] e_din;
        logic [15:0] e_rd;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        flush     = fl;
        #1;
        qs      = q.size();
        e_ready = (qs < DEPTH) && !fl;
        e_drain = (qs == DEPTH) || (qs > 0 && (fl || !v));
        e_load  = v && e_ready && !we;
        e_addr  = 9'h0;
        e_din   = 16'h0;
        if (e_drain) begin
            e_addr = q[0].addr;
            e_din  = q[0].data;
        end else if (e_load) begin
            e_addr = a;
        end
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("mem_we", 32'(mem_we), 32'(e_drain));
        chk("mem_address", 32'(mem_address), 32'(e_addr));
        chk("mem_data_in", 32'(mem_data_in), 32'(e_din));
        chk("count", 32'(count), 32'(qs));
        chk("empty", 32'(empty), 32'(qs == 0));
        e_rd = refmem[a];
        foreach (q[i]) if (q[i].addr == a) e_rd = q[i].data;
        if (e_drain) begin
            refmem[q[0].addr] = q[0].data;
            q.delete(0);
        end
        if (v && e_ready && we) q.push_back('{a, d});
        @(posedge clk);
        #1;
        if (e_load) last_rsp = e_rd;
        chk("rsp_valid", 32'(rsp_valid), 32'(e_load));
        chk("rsp_data", 32'(rsp_data), 32'(last_rsp));
        chk("count_post", 32'(count), 32'(q.size()));
        @(negedge clk);
    endtask

    task automatic idle_until_empty();
        for (int n = 0; n < 2 * DEPTH && q.size() > 0; n++) cycle(1'b0, 1'b0, 9'h0, 16'h0, 1'b0);
        chk("drained", 32'(empty), 32'(1));
    endtask

    initial begin
        for (int i = 0; i < 512; i++) refmem[i] = 16'h0000;
        last_rsp  = 16'h0000;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 9'h0;
        req_wdata = 16'h0;
        flush     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_data", 32'(rsp_data), 32'(0));
        chk("rst_mem_we", 32'(mem_we), 32'(0));
        reset = 1'b0;

        // single store, then idle drain
        cycle(1'b1, 1'b1, 9'd5, 16'h1234, 1'b0);
        cycle(1'b0, 1'b0, 9'd0, 16'h0, 1'b0);
        chk("t1_mem5", 32'(mem[5]), 32'h1234);
        chk("t1_empty", 32'(empty), 32'(1));

        // fill to DEPTH, then forced drain while req_valid held
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 9'(20 + i), 16'(16'hA0 + i), 1'b0);
        chk("t2_full_count", 32'(count), 32'(4));
        chk("t2_full_ready", 32'(req_ready), 32'(0));
        cycle(1'b1, 1'b1, 9'd99, 16'hDEAD, 1'b0);
        chk("t2_mem20", 32'(mem[20]), 32'h00A0);
        chk("t2_count3", 32'(count), 32'(3));
        chk("t2_ready_back", 32'(req_ready), 32'(1));
        idle_until_empty();

        // duplicate address: youngest forwarded, both drained in order
        cycle(1'b1, 1'b1, 9'd7, 16'h00AA, 1'b0);
        cycle(1'b1, 1'b1, 9'd7, 16'h00BB, 1'b0);
        cycle(1'b1, 1'b0, 9'd7, 16'h0, 1'b0);
        chk("t3_fwd", 32'(rsp_data), 32'h00BB);
        chk("t3_mem7_unwritten", 32'(mem[7]), 32'h0000);
        idle_until_empty();
        chk("t3_mem7", 32'(mem[7]), 32'h00BB);

        // load served from memory
        cycle(1'b1, 1'b1, 9'd30, 16'h5A5A, 1'b0);
        idle_until_empty();
        cycle(1'b1, 1'b0, 9'd30, 16'h0, 1'b0);
        chk("t4_mem_load", 32'(rsp_data), 32'h5A5A);

        // flush with requests pending upstream
        cycle(1'b1, 1'b1, 9'd1, 16'h0011, 1'b0);
        cycle(1'b1, 1'b1, 9'd2, 16'h0022, 1'b0);
        cycle(1'b1, 1'b1, 9'd50, 16'hBEEF, 1'b1);
        cycle(1'b1, 1'b1, 9'd50, 16'hBEEF, 1'b1);
        chk("t5_empty", 32'(empty), 32'(1));
        chk("t5_mem2", 32'(mem[2]), 32'h0022);
        cycle(1'b0, 1'b0, 9'd0, 16'h0, 1'b1);

        // asynchronous reset with stores pending and a response just issued
        cycle(1'b1, 1'b1, 9'd60, 16'h0600, 1'b0);
        cycle(1'b1, 1'b1, 9'd61, 16'h0601, 1'b0);
        cycle(1'b1, 1'b1, 9'd62, 16'h0602, 1'b0);
        cycle(1'b1, 1'b0, 9'd61, 16'h0, 1'b0);
        reset     = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("t6_count", 32'(count), 32'(0));
        chk("t6_empty", 32'(empty), 32'(1));
        chk("t6_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("t6_mem_we", 32'(mem_we), 32'(0));
        q.delete();
        last_rsp = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) cycle(1'b0, 1'b0, 9'h0, 16'h0, 1'b0);
        chk("t6_mem60", 32'(mem[60]), 32'h0000);

        // randomized traffic over a small address window to provoke collisions
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  9'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 7) == 0);
        end
        for (int n = 0; n < 2 * DEPTH && q.size() > 0; n++) cycle(1'b0, 1'b0, 9'h0, 16'h0, 1'b1);
        chk("rand_empty", 32'(empty), 32'(1));
        for (int a = 0; a < 16; a++) chk("rand_mem", 32'(mem[a]), 32'(refmem[a]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
